// File: rtl/button_ctrl_pkg.sv
// Shared types and constants for the button gesture classifier.
package button_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_P1   = 3'd1,
    ST_LONG = 3'd2,
    ST_W2   = 3'd3,
    ST_P2   = 3'd4
  } btn_state_e;

  localparam int MS_CNT_W = 16;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [MS_CNT_W-1:0] ms_sat_inc(input logic [MS_CNT_W-1:0] v);
    return (v == {MS_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: counts 0..PRESC-1, flags the terminal count, clears synchronously.
module ms_tick_gen #(
  parameter int PRESC = 10_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic ms_tick
);

  localparam int CW = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || cnt_q == LAST) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign ms_tick = (cnt_q == LAST);

endmodule

// File: rtl/button_event_ctrl.sv
// Classifies debounced button activity into short / long / repeat / double-click pulses.
module button_event_ctrl
  import button_ctrl_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 10_000_000,
  parameter int IS_PULLUP   = 0,
  parameter int LONG_MS     = 800,
  parameter int DBL_MS      = 250,
  parameter int REPEAT_MS   = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_valid,
  input  logic       btn_level,
  output logic       pressed,
  output logic       short_press,
  output logic       long_press,
  output logic       repeat_pulse,
  output logic       double_click,
  output logic [2:0] state_o
);

  localparam int   PRESC     = CLK_FREQ_HZ / 1000;
  localparam logic PRESS_LVL = (IS_PULLUP == 0) ? 1'b1 : 1'b0;
  localparam logic [MS_CNT_W-1:0] LONG_LIM = MS_CNT_W'(LONG_MS);
  localparam logic [MS_CNT_W-1:0] DBL_LIM  = MS_CNT_W'(DBL_MS);
  localparam logic [MS_CNT_W-1:0] REP_LIM  = MS_CNT_W'(REPEAT_MS);

  btn_state_e          state_q, state_d;
  logic [MS_CNT_W-1:0] ms_cnt_q, ms_cnt_d, ms_nxt;
  logic                pressed_q, pressed_d;
  logic                short_q, short_d, long_q, long_d;
  logic                rpt_q, rpt_d, dbl_q, dbl_d;
  logic                ms_tick, trans, rpt_restart;
  logic                press_ev, release_ev;
  logic                hit_long, hit_dbl, hit_rep;

  assign press_ev   = btn_valid & (btn_level == PRESS_LVL);
  assign release_ev = btn_valid & (btn_level != PRESS_LVL);

  // A limit is reached on the tick that would carry the counter onto it.
  assign ms_nxt   = ms_sat_inc(ms_cnt_q);
  assign hit_long = ms_tick && (ms_nxt == LONG_LIM);
  assign hit_dbl  = ms_tick && (ms_nxt == DBL_LIM);
  assign hit_rep  = ms_tick && (ms_nxt == REP_LIM);

  ms_tick_gen #(.PRESC(PRESC)) u_ms_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (trans),
    .ms_tick (ms_tick)
  );

  // Events are tested before timeouts so a coincident tick is dropped.
  always_comb begin
    state_d     = state_q;
    short_d     = 1'b0;
    long_d      = 1'b0;
    rpt_d       = 1'b0;
    dbl_d       = 1'b0;
    rpt_restart = 1'b0;
    case (state_q)
      ST_IDLE: if (press_ev) state_d = ST_P1;
      ST_P1: begin
        if (release_ev)    state_d = ST_W2;
        else if (hit_long) begin state_d = ST_LONG; long_d = 1'b1; end
      end
      ST_LONG: begin
        if (release_ev)   state_d = ST_IDLE;
        else if (hit_rep) begin rpt_d = 1'b1; rpt_restart = 1'b1; end
      end
      ST_W2: begin
        if (press_ev)     state_d = ST_P2;
        else if (hit_dbl) begin state_d = ST_IDLE; short_d = 1'b1; end
      end
      ST_P2: if (release_ev) begin state_d = ST_IDLE; dbl_d = 1'b1; end
      default: state_d = ST_IDLE;
    endcase
  end

  assign trans = (state_d != state_q);

  always_comb begin
    ms_cnt_d = ms_cnt_q;
    if (trans || rpt_restart) ms_cnt_d = '0;
    else if (ms_tick)         ms_cnt_d = ms_nxt;
  end

  assign pressed_d = btn_valid ? (btn_level == PRESS_LVL) : pressed_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ms_cnt_q  <= '0;
      pressed_q <= 1'b0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      rpt_q     <= 1'b0;
      dbl_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ms_cnt_q  <= ms_cnt_d;
      pressed_q <= pressed_d;
      short_q   <= short_d;
      long_q    <= long_d;
      rpt_q     <= rpt_d;
      dbl_q     <= dbl_d;
    end
  end

  assign pressed      = pressed_q;
  assign short_press  = short_q;
  assign long_press   = long_q;
  assign repeat_pulse = rpt_q;
  assign double_click = dbl_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed bench: active-high (index 0) and pull-up (index 1) instances driven in lockstep.
module tb_button_event_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_valid = 1'b0;
  logic       btn_level = 1'b0;
  logic       btn_level_n;
  logic [1:0] pr, sp, lp, rp, dc;
  logic [2:0] st [2];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int sp_n[2], lp_n[2], rp_n[2], dc_n[2], multi[2];
  int sp_at[2], lp_at[2], rp_first[2], rp_last[2], dc_at[2];
  int t0;

  assign btn_level_n = ~btn_level;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  button_event_ctrl #(.CLK_FREQ_HZ(10_000), .IS_PULLUP(0), .LONG_MS(8), .DBL_MS(3), .REPEAT_MS(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .btn_valid(btn_valid), .btn_level(btn_level),
    .pressed(pr[0]), .short_press(sp[0]), .long_press(lp[0]), .repeat_pulse(rp[0]),
    .double_click(dc[0]), .state_o(st[0])
  );

  button_event_ctrl #(.CLK_FREQ_HZ(10_000), .IS_PULLUP(1), .LONG_MS(8), .DBL_MS(3), .REPEAT_MS(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .btn_valid(btn_valid), .btn_level(btn_level_n),
    .pressed(pr[1]), .short_press(sp[1]), .long_press(lp[1]), .repeat_pulse(rp[1]),
    .double_click(dc[1]), .state_o(st[1])
  );

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        if (sp[i]) begin sp_n[i]++; sp_at[i] = cyc; end
        if (lp[i]) begin lp_n[i]++; lp_at[i] = cyc; end
        if (dc[i]) begin dc_n[i]++; dc_at[i] = cyc; end
        if (rp[i]) begin
          if (rp_n[i] == 0) rp_first[i] = cyc;
          rp_n[i]++;
          rp_last[i] = cyc;
        end
        if (int'(sp[i]) + int'(lp[i]) + int'(rp[i]) + int'(dc[i]) > 1) multi[i]++;
      end
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic mon_clr();
    for (int i = 0; i < 2; i++) begin
      sp_n[i] = 0; lp_n[i] = 0; rp_n[i] = 0; dc_n[i] = 0; multi[i] = 0;
      sp_at[i] = -1; lp_at[i] = -1; rp_first[i] = -1; rp_last[i] = -1; dc_at[i] = -1;
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Drives a press (1) or release (0) as seen by the active-high instance.
  task automatic strobe(input logic lvl);
    btn_level = lvl;
    btn_valid = 1'b1;
    step(1);
    btn_valid = 1'b0;
  endtask

  task automatic chk_state(input string tag, input int exp);
    for (int i = 0; i < 2; i++) chk($sformatf("%s_st%0d", tag, i), int'(st[i]), exp);
  endtask

  task automatic chk_counts(input string tag, input int e_sp, input int e_lp, input int e_rp, input int e_dc);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_sp_n%0d", tag, i), sp_n[i], e_sp);
      chk($sformatf("%s_lp_n%0d", tag, i), lp_n[i], e_lp);
      chk($sformatf("%s_rp_n%0d", tag, i), rp_n[i], e_rp);
      chk($sformatf("%s_dc_n%0d", tag, i), dc_n[i], e_dc);
      chk($sformatf("%s_multi%0d", tag, i), multi[i], 0);
    end
  endtask

  initial begin
    mon_clr();
    step(2);
    chk_state("rst", 0);
    for (int i = 0; i < 2; i++)
      chk($sformatf("rst_outs%0d", i), int'({pr[i], sp[i], lp[i], rp[i], dc[i]}), 0);
    rst_n = 1'b1;
    step(3);

    // Short press: release after 30 cycles, timeout 30 cycles into W2.
    mon_clr(); t0 = cyc;
    strobe(1'b1);
    chk_state("sp_p1", 1);
    for (int i = 0; i < 2; i++) chk($sformatf("sp_pressed%0d", i), int'(pr[i]), 1);
    step(29);
    strobe(1'b0);
    chk_state("sp_w2", 3);
    for (int i = 0; i < 2; i++) chk($sformatf("sp_released%0d", i), int'(pr[i]), 0);
    step(60);
    chk_counts("sp", 1, 0, 0, 0);
    for (int i = 0; i < 2; i++) chk($sformatf("sp_at%0d", i), sp_at[i], t0 + 61);
    chk_state("sp_end", 0);

    // Long hold with a stray duplicate press, then release.
    mon_clr(); t0 = cyc;
    strobe(1'b1);
    step(150);
    strobe(1'b1);
    chk_state("lp_dup", 2);
    step(52);
    chk_state("lp_long", 2);
    strobe(1'b0);
    step(40);
    chk_counts("lp", 0, 1, 6, 0);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("lp_at%0d", i), lp_at[i], t0 + 81);
      chk($sformatf("rp_first%0d", i), rp_first[i], t0 + 101);
      chk($sformatf("rp_last%0d", i), rp_last[i], t0 + 201);
    end
    chk_state("lp_end", 0);

    // Double click: 15-cycle gap.
    mon_clr(); t0 = cyc;
    strobe(1'b1);
    step(19);
    strobe(1'b0);
    step(14);
    strobe(1'b1);
    chk_state("dc_p2", 4);
    step(9);
    strobe(1'b0);
    step(60);
    chk_counts("dc", 0, 0, 0, 1);
    for (int i = 0; i < 2; i++) chk($sformatf("dc_at%0d", i), dc_at[i], t0 + 46);
    chk_state("dc_end", 0);

    // Second press on the very cycle the double-click window expires.
    mon_clr();
    strobe(1'b1);
    step(19);
    strobe(1'b0);
    step(29);
    strobe(1'b1);
    chk_state("edge_p2", 4);
    strobe(1'b0);
    step(60);
    chk_counts("edge", 0, 0, 0, 1);

    // Gap too long: short press, then the second press starts a fresh P1.
    mon_clr(); t0 = cyc;
    strobe(1'b1);
    step(19);
    strobe(1'b0);
    step(34);
    strobe(1'b1);
    chk_state("gap_p1", 1);
    step(85);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("gap_sp_at%0d", i), sp_at[i], t0 + 51);
      chk($sformatf("gap_lp_at%0d", i), lp_at[i], t0 + 136);
    end
    strobe(1'b0);
    step(5);
    chk_counts("gap", 1, 1, 0, 0);

    // Reset mid-gesture, then keep holding with no new press event.
    mon_clr();
    strobe(1'b1);
    step(49);
    #1 rst_n = 1'b0;
    #1;
    chk_state("mrst", 0);
    for (int i = 0; i < 2; i++)
      chk($sformatf("mrst_outs%0d", i), int'({pr[i], sp[i], lp[i], rp[i], dc[i]}), 0);
    step(3);
    rst_n = 1'b1;
    step(200);
    chk_counts("mrst", 0, 0, 0, 0);
    chk_state("mrst_end", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_event_ctrl.md
BUTTON_EVENT_CTRL -- requirements
Module: button_event_ctrl

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 10_000_000, system clock frequency in Hz.
REQ-002 Parameter IS_PULLUP, default 0; 1 = pressed reads 0, 0 = pressed reads 1.
REQ-003 Parameter LONG_MS, default 800, hold time in ms that classifies a long press.
REQ-004 Parameter DBL_MS, default 250, max release gap in ms for a double click.
REQ-005 Parameter REPEAT_MS, default 200, auto-repeat period in ms while long-held.
REQ-006 Port clk  input  1  single system clock, rising edge.
REQ-007 Port rst_n  input  1  asynchronous active-low reset.
REQ-008 Port btn_valid  input  1  one-cycle strobe on a debounced level change.
REQ-009 Port btn_level  input  1  debounced button level, sampled only when btn_valid=1.
REQ-010 Port pressed  output  1  1 while the last accepted level is the pressed level.
REQ-011 Port short_press  output  1  one-cycle pulse on a single short press.
REQ-012 Port long_press  output  1  one-cycle pulse when a hold reaches LONG_MS.
REQ-013 Port repeat_pulse  output  1  one-cycle pulse every REPEAT_MS while long-held.
REQ-014 Port double_click  output  1  one-cycle pulse on a completed second press.
REQ-015 Port state_o  output  3  current FSM state encoding, for debug only.

Function
REQ-016 Press event = btn_valid & (btn_level == ~IS_PULLUP); release event = btn_valid & (btn_level == IS_PULLUP).
REQ-017 Prescaler counts 0..PRESC-1 with PRESC = CLK_FREQ_HZ/1000; ms_tick pulses when it reaches PRESC-1.
REQ-018 Prescaler and ms counter (16 bit, saturating) SHALL both clear on every state transition.
REQ-019 States: IDLE, P1 (first press held), LONG (long hold), W2 (waiting for second press), P2 (second press held).
REQ-020 IDLE: press -> P1; release is ignored.
REQ-021 P1: release before the ms counter reaches LONG_MS -> W2; ms counter reaches LONG_MS -> LONG and long_press pulses.
REQ-022 LONG: repeat_pulse each time the ms counter reaches REPEAT_MS, after which the counter restarts from 0; release -> IDLE with no pulse.
REQ-023 W2: press before DBL_MS -> P2; ms counter reaches DBL_MS -> IDLE and short_press pulses.
REQ-024 P2: release -> IDLE and double_click pulses; no long or repeat classification in P2.
REQ-025 All pulse outputs are registered and assert in the cycle following the triggering edge/timeout; at most one pulse output is high per cycle.
REQ-026 Event and ms_tick in the same cycle: the event wins, and the timeout for that cycle is discarded.
REQ-027 A press in P1/LONG/P2, or a release in W2, is impossible from the debouncer; if it occurs, state is held and only pressed updates.
REQ-028 pressed updates in the cycle after each btn_valid, independent of FSM state.

Reset
REQ-029 On rst_n low, asynchronously: state IDLE, prescaler 0, ms counter 0, all pulse outputs 0.
REQ-030 pressed resets to 0, and state_o resets to the IDLE encoding.
REQ-031 Reset mid-gesture discards the gesture; after release of reset no pulse is emitted until a new press is received.

Structure
REQ-032 Shared package button_ctrl_pkg holds the state typedef/encodings (IDLE=0, P1=1, LONG=2, W2=3, P2=4) and the ms-counter width constant.
REQ-033 Sub-module ms_tick_gen (prescaler with synchronous clear input and ms_tick output) is instantiated once.
REQ-034 The block connects directly to the debouncer's out_valid/debounced_button outputs, with no extra synchronisation.

Verification (CLK_FREQ_HZ=10_000 giving PRESC=10; LONG_MS=8, DBL_MS=3, REPEAT_MS=2; IS_PULLUP=0)
REQ-035 Press, then release after 30 cycles -> short_press exactly once, 30 cycles (3 ms) after entering W2; no other pulses.
REQ-036 Press held 200 cycles -> long_press 80 cycles after entering P1, then repeat_pulse every 20 cycles (6 pulses); release -> IDLE.
REQ-037 Press, release after 20 cycles, press again 15 cycles later, release -> a single double_click and no short_press.
REQ-038 Release gap of 35 cycles between presses -> short_press, then the second press is treated as a new P1.
REQ-039 rst_n asserted in P1 after 50 cycles -> outputs 0 and state IDLE immediately; no long_press when held afterwards without a new press event.
REQ-040 With IS_PULLUP=1, press = btn_level 0 -> same sequences as REQ-035 and REQ-036 with inverted input.
